poly_pair_tx: RTL and testbench

POLY_PAIR_TX -- requirements
Module: poly_pair_tx

---
 rtl/poly_pkg.sv | 14 +
 rtl/kyber_csub.sv | 18 +
 rtl/poly_pair_tx.sv | 121 ++++++++++++
 tb/tb_poly_pair_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared Kyber constants and the pair-streamer FSM state type.
package poly_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_PAIR,
        SEND,
        FINISH
    } tx_state_t;

endpackage

// File: rtl/kyber_csub.sv
// Combinational conditional subtraction of KYBER_Q (x >= q ? x - q : x).
// Only compiled when POLY_PAIR_TX_CSUB_EN is defined, the sole build that instantiates it.
`ifdef POLY_PAIR_TX_CSUB_EN
module kyber_csub
    import poly_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    localparam logic [WIDTH-1:0] Q = WIDTH'(KYBER_Q);

    assign y = (x >= Q) ? (x - Q) : x;

endmodule
`endif

// File: rtl/poly_pair_tx.sv
// Coefficient buffer that streams its contents out as (even, odd) pairs with a ready/valid handshake.
// Define POLY_PAIR_TX_CSUB_EN to reduce each output coefficient modulo KYBER_Q by one conditional subtract.
module poly_pair_tx
    import poly_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic             readin_ok,
    output logic             readin,
    output logic [WIDTH-1:0] din_1,
    output logic [WIDTH-1:0] din_2,
    output logic [DEPTH-1:0] in_index,
    output logic             full_in,
    output logic             busy,
    output logic             done
);

    localparam int N = 1 << DEPTH;
    localparam logic [DEPTH-1:0] LAST_PTR = DEPTH'(N - 2);

    logic [WIDTH-1:0] mem [N];

    tx_state_t        state;
    logic [DEPTH-1:0] ptr;
    logic [DEPTH-1:0] rd_even;
    logic [DEPTH-1:0] rd_odd;
    logic [WIDTH-1:0] raw_even;
    logic [WIDTH-1:0] raw_odd;
    logic [WIDTH-1:0] out_even;
    logic [WIDTH-1:0] out_odd;
    logic             xfer;

    // In SEND the read port looks one pair ahead so a transfer can reload on the same edge.
    always_comb begin
        rd_even  = (state == SEND) ? (ptr + DEPTH'(2)) : ptr;
        rd_odd   = rd_even + DEPTH'(1);
        raw_even = mem[rd_even];
        raw_odd  = mem[rd_odd];
    end

`ifdef POLY_PAIR_TX_CSUB_EN
    kyber_csub #(.WIDTH(WIDTH)) u_csub_even (.x(raw_even), .y(out_even));
    kyber_csub #(.WIDTH(WIDTH)) u_csub_odd  (.x(raw_odd),  .y(out_odd));
`else
    assign out_even = raw_even;
    assign out_odd  = raw_odd;
`endif

    assign xfer = readin && readin_ok;

    // Buffer is never cleared by reset, so a stream can be repeated after an abort.
    always_ff @(posedge clk) begin
        if (!reset && set && (state == IDLE) && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            readin   <= 1'b0;
            full_in  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            din_1    <= '0;
            din_2    <= '0;
            in_index <= '0;
        end else if (set) begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= LOAD_PAIR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD_PAIR: begin
                    din_2    <= out_even;
                    din_1    <= out_odd;
                    in_index <= ptr;
                    full_in  <= (ptr == LAST_PTR);
                    readin   <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        if (ptr == LAST_PTR) begin
                            readin  <= 1'b0;
                            full_in <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= FINISH;
                        end else begin
                            ptr      <= ptr + DEPTH'(2);
                            din_2    <= out_even;
                            din_1    <= out_odd;
                            in_index <= rd_even;
                            full_in  <= (rd_even == LAST_PTR);
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_pair_tx.sv
// Directed self-checking bench for poly_pair_tx (default DEPTH=8, WIDTH=16).
module tb_poly_pair_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        set;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        readin_ok;
    logic        readin;
    logic [15:0] din_1;
    logic [15:0] din_2;
    logic [7:0]  in_index;
    logic        full_in;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int exp_mem [256];

    poly_pair_tx #(.DEPTH(8), .WIDTH(16)) dut (
        .clk(clk), .reset(reset), .set(set), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .readin_ok(readin_ok), .readin(readin),
        .din_1(din_1), .din_2(din_2), .in_index(in_index), .full_in(full_in),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_val(input int v);
`ifdef POLY_PAIR_TX_CSUB_EN
        return (v >= 3329) ? v - 3329 : v;
`else
        return v;
`endif
    endfunction

    task automatic wait_done(input string tag, input int budget);
        for (int n = 0; n < budget && done !== 1'b1; n++) tick();
        check_output(tag, done, 1);
        tick();
    endtask

    // Full stream with readin_ok held high, optionally writing one word in the start cycle.
    task automatic stream_check(input string tag, input bit write_too, input int addr, input int data);
        readin_ok = 1'b1;
        start     = 1'b1;
        if (write_too) begin
            wr_en   = 1'b1;
            wr_addr = 8'(addr);
            wr_data = 16'(data);
            exp_mem[addr] = data;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check_output({tag, "_lat_readin"}, readin, 0);
        check_output({tag, "_lat_busy"}, busy, 1);
        tick();
        for (int k = 0; k < 128; k++) begin
            check_output({tag, "_readin"}, readin, 1);
            check_output({tag, "_index"}, in_index, 2 * k);
            check_output({tag, "_din_2"}, din_2, exp_val(exp_mem[2 * k]));
            check_output({tag, "_din_1"}, din_1, exp_val(exp_mem[2 * k + 1]));
            check_output({tag, "_full_in"}, full_in, (k == 127) ? 1 : 0);
            tick();
        end
        check_output({tag, "_end_readin"}, readin, 0);
        check_output({tag, "_end_done"}, done, 1);
        check_output({tag, "_end_busy"}, busy, 0);
        tick();
        check_output({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int cnt;
        int expi;

        reset     = 1'b1;
        set       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        readin_ok = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_output("rst_readin", readin, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_full_in", full_in, 0);
        check_output("rst_index", in_index, 0);
        check_output("rst_din_1", din_1, 0);
        check_output("rst_din_2", din_2, 0);

        for (int i = 0; i < 256; i++) begin
            wr_en   = 1'b1;
            wr_addr = 8'(i);
            wr_data = 16'(i);
            exp_mem[i] = i;
            tick();
        end
        wr_en = 1'b0;

        $display("[TB] streaming with readin_ok high");
        stream_check("ramp", 1'b0, 0, 0);

        $display("[TB] streaming with readin_ok toggling");
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cnt  = 0;
        expi = 0;
        for (int c = 0; c < 1000 && cnt < 128; c++) begin
            readin_ok = (c % 2 == 0);
            check_output("tog_readin", readin, 1);
            check_output("tog_index", in_index, expi);
            check_output("tog_din_2", din_2, exp_val(exp_mem[expi]));
            if (readin_ok) begin
                expi += 2;
                cnt++;
            end
            tick();
        end
        check_output("tog_count", cnt, 128);
        check_output("tog_done", done, 1);
        tick();

        $display("[TB] reset mid-stream");
        readin_ok = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int n = 0; n < 200 && in_index != 8'd100; n++) tick();
        check_output("abort_at_index", in_index, 100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("abort_readin", readin, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_index", in_index, 0);
        stream_check("restream", 1'b0, 0, 0);

        $display("[TB] freeze, late start and late write");
        readin_ok = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int n = 0; n < 10; n++) tick();
        check_output("frz_before", in_index, 20);
        set = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            check_output("frz_index", in_index, 20);
            check_output("frz_readin", readin, 1);
            check_output("frz_din_1", din_1, exp_val(exp_mem[21]));
        end
        set = 1'b1;
        tick();
        check_output("frz_resume", in_index, 22);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("late_start_index", in_index, 24);
        check_output("late_start_busy", busy, 1);
        readin_ok = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 8'd0;
        wr_data   = 16'hFFFF;
        tick();
        wr_en = 1'b0;
        check_output("late_wr_stall", in_index, 24);
        readin_ok = 1'b1;
        wait_done("late_wr_done", 300);
        stream_check("late_wr_ignored", 1'b0, 0, 0);

        $display("[TB] values near the modulus, write in the start cycle");
        wr_en   = 1'b1;
        wr_addr = 8'd0;
        wr_data = 16'd3330;
        exp_mem[0] = 3330;
        tick();
        wr_en = 1'b0;
        stream_check("modq", 1'b1, 1, 3328);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
